// File: rtl/sw_seq_feeder.sv
// Host-side feeder for the Smith-Waterman scoring core.
// The host loads packed query (S) and target (T) words while idle. A start
// request resets the core, streams SEQ_LEN base pairs back to back, then
// waits for the core's finish (or a timeout) and captures the max score.
module sw_seq_feeder #(
  parameter int SEQ_LEN = 256,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [11:0]       score,
  output logic              sw_rst,
  output logic              sw_valid,
  output logic [1:0]        sw_data_s,
  output logic [1:0]        sw_data_t,
  input  logic              sw_finish,
  input  logic [11:0]       sw_max
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TO  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;       // index of the base pair currently on the outputs
  logic [CNT_W-1:0]  wait_cnt;  // cycles spent waiting for the core

  logic [7:0]        buf_s [2**ADDR_W];
  logic [7:0]        buf_t [2**ADDR_W];

  logic [ADDR_W+1:0] rd_idx;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        base_sel;
  logic [7:0]        word_s;
  logic [7:0]        word_t;

  // Pick base k out of a packed word; base 0 sits in the low bits.
  function automatic logic [1:0] base_of(input logic [7:0] w, input logic [1:0] k);
    logic [1:0] b;
    case (k)
      2'd0:    b = w[1:0];
      2'd1:    b = w[3:2];
      2'd2:    b = w[5:4];
      default: b = w[7:6];
    endcase
    return b;
  endfunction

  // Address of the next base to issue: 0 from CLR, idx+1 while streaming.
  always_comb begin
    rd_idx = '0;
    if (state == STREAM) begin
      rd_idx = (ADDR_W+2)'(idx) + (ADDR_W+2)'(1);
    end
  end

  assign word_addr = rd_idx[ADDR_W+1:2];
  assign base_sel  = rd_idx[1:0];
  assign word_s    = buf_s[word_addr];
  assign word_t    = buf_t[word_addr];

  // Host writes land only while idle so the buffers are frozen during a run.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) begin
      if (wr_sel) begin
        buf_t[wr_addr] <= wr_data;
      end else begin
        buf_s[wr_addr] <= wr_data;
      end
    end
  end

  // Run sequencer with all interface outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      score     <= '0;
      sw_rst    <= 1'b0;
      sw_valid  <= 1'b0;
      sw_data_s <= '0;
      sw_data_t <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            timeout <= 1'b0;
            sw_rst  <= 1'b1;
            busy    <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          // Core reset ends and base pair 0 goes out on the same edge.
          sw_rst    <= 1'b0;
          sw_valid  <= 1'b1;
          sw_data_s <= base_of(word_s, base_sel);
          sw_data_t <= base_of(word_t, base_sel);
          idx       <= '0;
          state     <= STREAM;
        end
        STREAM: begin
          if (idx == LAST_IDX) begin
            sw_valid  <= 1'b0;
            sw_data_s <= '0;
            sw_data_t <= '0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end else begin
            sw_valid  <= 1'b1;
            sw_data_s <= base_of(word_s, base_sel);
            sw_data_t <= base_of(word_t, base_sel);
            idx       <= idx + CNT_W'(1);
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // A finish arriving on the final allowed cycle still counts.
          if (sw_finish) begin
            score <= sw_max;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (wait_cnt == LAST_TO) begin
            timeout <= 1'b1;
            score   <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Bench for sw_seq_feeder: a core stub answers each run after a chosen
// delay, and every run is compared against a bench-side copy of the buffers.
`timescale 1ns/1ps
module tb_sw_seq_feeder;

  localparam int SEQ_LEN = 256;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 1023;
  localparam int CNT_W   = 10;
  localparam int WORDS   = SEQ_LEN / 4;
  localparam int BUDGET  = SEQ_LEN + TIMEOUT + 40;
  localparam int T_DONE  = SEQ_LEN + 2 + TIMEOUT;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [11:0]       score;
  logic              sw_rst;
  logic              sw_valid;
  logic [1:0]        sw_data_s;
  logic [1:0]        sw_data_t;
  logic              sw_finish;
  logic [11:0]       sw_max;

  int tests = 0;
  int fails = 0;

  // Bench copy of what the host has written.
  logic [7:0] m_s [WORDS];
  logic [7:0] m_t [WORDS];

  // Core stub controls.
  int          stub_delay = 10;
  bit          stub_never = 1'b0;
  logic [11:0] stub_max   = 12'h0;
  int          stub_cnt   = -1;

  // What one run looked like from the outside.
  int         cap_rst_cnt, cap_rst_first, cap_vfirst, cap_vlast, cap_vcount, cap_done_c;
  logic [1:0] cap_s [$];
  logic [1:0] cap_t [$];
  logic [11:0] cap_score;
  logic       cap_to, cap_busy_at_done, cap_done_after, cap_busy_gap, cap_leak, cap_to_c1;

  sw_seq_feeder #(
    .SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .score(score), .sw_rst(sw_rst), .sw_valid(sw_valid), .sw_data_s(sw_data_s),
    .sw_data_t(sw_data_t), .sw_finish(sw_finish), .sw_max(sw_max)
  );

  always #5 clk = ~clk;

  // Core stub: finish (level) stub_delay cycles after the last valid, cleared by sw_rst.
  initial begin
    sw_finish = 1'b0;
    sw_max    = 12'h0;
    forever begin
      @(negedge clk);
      if (reset || sw_rst) begin
        sw_finish = 1'b0;
        stub_cnt  = -1;
      end else if (sw_valid) begin
        stub_cnt = 0;
      end else if (stub_cnt >= 0 && !sw_finish) begin
        stub_cnt++;
        if (!stub_never && stub_cnt == stub_delay) begin
          sw_finish = 1'b1;
          sw_max    = stub_max;
        end else begin
          sw_max = 12'($urandom);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: base i of a sequence is bits [2(i%4)+1 : 2(i%4)] of word i/4.
  function automatic logic [1:0] mbase(input bit sel, input int i);
    logic [7:0] w;
    w = sel ? m_t[i / 4] : m_s[i / 4];
    return 2'((w >> (2 * (i % 4))) & 8'h03);
  endfunction

  function automatic int stream_errs();
    int e = 0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i >= cap_s.size()) e++;
      else if (cap_s[i] !== mbase(1'b0, i) || cap_t[i] !== mbase(1'b1, i)) e++;
    end
    return e;
  endfunction

  // Expected done cycle (counted from the start edge) for the stub settings.
  function automatic int exp_done_c();
    if (!stub_never && stub_delay <= TIMEOUT) return SEQ_LEN + 2 + stub_delay;
    return T_DONE;
  endfunction

  task automatic fill_buffers(input bit rnd);
    for (int sel = 0; sel < 2; sel++) begin
      for (int w = 0; w < WORDS; w++) begin
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel[0];
        wr_addr = ADDR_W'(w);
        wr_data = rnd ? 8'($urandom) : (sel == 0 ? 8'hE4 : 8'h1B);
        if (sel == 0) m_s[w] = wr_data;
        else          m_t[w] = wr_data;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Raise start, then record every cycle of the run until done (plus one).
  task automatic capture_run(input bit hold, input int wr_c, input int start_c);
    cap_rst_cnt = 0; cap_rst_first = 0; cap_vfirst = 0; cap_vlast = 0;
    cap_vcount = 0; cap_done_c = 0; cap_score = 'x; cap_to = 1'bx;
    cap_busy_at_done = 1'bx; cap_done_after = 1'bx; cap_busy_gap = 1'b0;
    cap_leak = 1'b0; cap_to_c1 = 1'bx;
    cap_s.delete();
    cap_t.delete();
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (c == 1) cap_to_c1 = timeout;
      if (sw_rst) begin
        cap_rst_cnt++;
        if (cap_rst_first == 0) cap_rst_first = c;
      end
      if (sw_valid) begin
        if (cap_vfirst == 0) cap_vfirst = c;
        cap_vlast = c;
        cap_vcount++;
        cap_s.push_back(sw_data_s);
        cap_t.push_back(sw_data_t);
      end else if (sw_data_s != 2'd0 || sw_data_t != 2'd0) begin
        cap_leak = 1'b1;
      end
      if (!done && !busy) cap_busy_gap = 1'b1;
      wr_en = (c == wr_c);
      if (c == wr_c) begin
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = 8'hFF;
      end
      if (start_c != 0) start = (c == start_c);
      if (done) begin
        cap_done_c       = c;
        cap_score        = score;
        cap_to           = timeout;
        cap_busy_at_done = busy;
        @(negedge clk);
        cap_done_after = done;
        wr_en = 1'b0;
        break;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, timeout, score, sw_rst, sw_valid, sw_data_s, sw_data_t} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b to=%b score=%h rst=%b vld=%b s=%0d t=%0d want all 0",
               busy, done, timeout, score, sw_rst, sw_valid, sw_data_s, sw_data_t);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || sw_rst !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b sw_rst=%b want 0 0", busy, sw_rst);
    end
  endtask

  task automatic test_stream_pattern();
    fill_buffers(1'b0);
    stub_never = 1'b0; stub_delay = 10; stub_max = 12'h7FF;
    capture_run(1'b0, 0, 0);
    tests++; if (cap_rst_cnt !== 1 || cap_rst_first !== 1) begin fails++;
      $display("FAIL pat_sw_rst: got %0d pulses first at %0d want 1 at 1", cap_rst_cnt, cap_rst_first); end
    tests++; if (cap_vfirst !== 2) begin fails++;
      $display("FAIL pat_first_valid: got cycle %0d want 2", cap_vfirst); end
    tests++; if (cap_vlast !== SEQ_LEN + 1) begin fails++;
      $display("FAIL pat_last_valid: got cycle %0d want %0d", cap_vlast, SEQ_LEN + 1); end
    tests++; if (cap_vcount !== SEQ_LEN) begin fails++;
      $display("FAIL pat_valid_count: got %0d want %0d", cap_vcount, SEQ_LEN); end
    tests++; if (stream_errs() !== 0) begin fails++;
      $display("FAIL pat_stream_data: got %0d bad bases want 0", stream_errs()); end
    tests++; if (cap_s.size() > 5 && (cap_s[4] !== 2'd0 || cap_s[5] !== 2'd1 || cap_t[4] !== 2'd3 || cap_t[5] !== 2'd2)) begin fails++;
      $display("FAIL pat_order: got s=%0d,%0d t=%0d,%0d want s=0,1 t=3,2", cap_s[4], cap_s[5], cap_t[4], cap_t[5]); end
    tests++; if (cap_leak !== 1'b0) begin fails++;
      $display("FAIL pat_data_idle: got nonzero data without valid, want 0"); end
    tests++; if (cap_done_c !== SEQ_LEN + 12) begin fails++;
      $display("FAIL pat_done_cycle: got %0d want %0d", cap_done_c, SEQ_LEN + 12); end
    tests++; if (cap_score !== 12'h7FF || cap_to !== 1'b0) begin fails++;
      $display("FAIL pat_score: got score=%h to=%b want 7ff 0", cap_score, cap_to); end
    tests++; if (cap_busy_at_done !== 1'b0 || cap_done_after !== 1'b0) begin fails++;
      $display("FAIL pat_done_pulse: got busy_at_done=%b done_next=%b want 0 0", cap_busy_at_done, cap_done_after); end
    tests++; if (cap_busy_gap !== 1'b0) begin fails++;
      $display("FAIL pat_busy: got busy low before done, want high through the run"); end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      fill_buffers(1'b1);
      stub_never = 1'b0;
      stub_delay = $urandom_range(1, 60);
      stub_max   = 12'($urandom);
      capture_run(1'b0, 0, 0);
      tests++; if (cap_vfirst !== 2 || cap_vcount !== SEQ_LEN) begin fails++;
        $display("FAIL rnd%0d_valid: got first=%0d count=%0d want 2 %0d", r, cap_vfirst, cap_vcount, SEQ_LEN); end
      tests++; if (stream_errs() !== 0) begin fails++;
        $display("FAIL rnd%0d_stream: got %0d bad bases want 0", r, stream_errs()); end
      tests++; if (cap_done_c !== exp_done_c() || cap_score !== stub_max || cap_to !== 1'b0) begin fails++;
        $display("FAIL rnd%0d_result: got done@%0d score=%h to=%b want done@%0d score=%h to=0",
                 r, cap_done_c, cap_score, cap_to, exp_done_c(), stub_max); end
    end
  endtask

  task automatic test_timeout();
    stub_never = 1'b1;
    capture_run(1'b0, 0, 0);
    tests++; if (cap_done_c !== T_DONE || cap_to !== 1'b1 || cap_score !== 12'h0) begin fails++;
      $display("FAIL to_abort: got done@%0d to=%b score=%h want done@%0d to=1 score=0", cap_done_c, cap_to, cap_score, T_DONE); end
    repeat (5) @(negedge clk);
    tests++; if (timeout !== 1'b1) begin fails++;
      $display("FAIL to_sticky: got timeout=%b want 1", timeout); end
    // Finish on the last allowed cycle beats the timeout.
    stub_never = 1'b0; stub_delay = TIMEOUT; stub_max = 12'($urandom) | 12'h001;
    capture_run(1'b0, 0, 0);
    tests++; if (cap_to_c1 !== 1'b0) begin fails++;
      $display("FAIL to_cleared_by_start: got timeout=%b in CLR want 0", cap_to_c1); end
    tests++; if (cap_done_c !== T_DONE || cap_to !== 1'b0 || cap_score !== stub_max) begin fails++;
      $display("FAIL to_finish_wins: got done@%0d to=%b score=%h want done@%0d to=0 score=%h",
               cap_done_c, cap_to, cap_score, T_DONE, stub_max); end
    stub_delay = TIMEOUT + 1;
    capture_run(1'b0, 0, 0);
    tests++; if (cap_done_c !== T_DONE || cap_to !== 1'b1 || cap_score !== 12'h0) begin fails++;
      $display("FAIL to_late_finish: got done@%0d to=%b score=%h want done@%0d to=1 score=0", cap_done_c, cap_to, cap_score, T_DONE); end
  endtask

  task automatic test_write_during_run();
    fill_buffers(1'b0);
    stub_never = 1'b0; stub_delay = 5; stub_max = 12'h123;
    capture_run(1'b0, 50, 0);
    tests++; if (stream_errs() !== 0 || cap_vcount !== SEQ_LEN) begin fails++;
      $display("FAIL wr_ignored_run: got %0d bad bases count=%0d want 0 %0d", stream_errs(), cap_vcount, SEQ_LEN); end
    capture_run(1'b0, 0, 0);
    tests++; if (stream_errs() !== 0) begin fails++;
      $display("FAIL wr_ignored_rerun: got %0d bad bases want 0", stream_errs()); end
    // Write in the same idle cycle as start must be streamed.
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = 8'($urandom);
    m_t[0] = wr_data;
    capture_run(1'b0, 0, 0);
    tests++; if (stream_errs() !== 0) begin fails++;
      $display("FAIL wr_with_start: got %0d bad bases want 0", stream_errs()); end
  endtask

  task automatic test_reset_mid_run();
    int nv;
    bit hit;
    stub_never = 1'b0; stub_delay = 7; stub_max = 12'h5A5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    hit = 1'b0;
    for (int c = 0; c < 2 * SEQ_LEN; c++) begin
      if (sw_valid) nv++;
      if (nv == 100) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!hit) begin fails++;
      $display("FAIL rst_mid_reach: got %0d valid cycles want 100", nv); end
    reset = 1'b1;
    #1;
    tests++; if (sw_valid !== 1'b0 || busy !== 1'b0 || sw_rst !== 1'b0) begin fails++;
      $display("FAIL rst_mid_async: got valid=%b busy=%b sw_rst=%b want 0 0 0", sw_valid, busy, sw_rst); end
    tests++; if (score !== 12'h0 || timeout !== 1'b0) begin fails++;
      $display("FAIL rst_mid_clear: got score=%h to=%b want 0 0", score, timeout); end
    @(negedge clk);
    reset = 1'b0;
    capture_run(1'b0, 0, 0);
    tests++; if (cap_rst_first !== 1 || cap_vfirst !== 2 || cap_vcount !== SEQ_LEN || stream_errs() !== 0) begin fails++;
      $display("FAIL rst_mid_replay: got rst@%0d first=%0d count=%0d bad=%0d want 1 2 %0d 0",
               cap_rst_first, cap_vfirst, cap_vcount, stream_errs(), SEQ_LEN); end
    tests++; if (cap_done_c !== exp_done_c() || cap_score !== 12'h5A5) begin fails++;
      $display("FAIL rst_mid_result: got done@%0d score=%h want done@%0d score=5a5", cap_done_c, cap_score, exp_done_c()); end
  endtask

  task automatic test_back_to_back();
    bit extra;
    stub_never = 1'b0; stub_delay = 20; stub_max = 12'h0C3;
    capture_run(1'b0, 0, SEQ_LEN + 6);
    extra = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || sw_rst) extra = 1'b1;
    end
    tests++; if (extra !== 1'b0 || cap_done_c !== exp_done_c()) begin fails++;
      $display("FAIL start_in_wait: got extra_run=%b done@%0d want 0 done@%0d", extra, cap_done_c, exp_done_c()); end
    fill_buffers(1'b1);
    for (int r = 0; r < 2; r++) begin
      stub_delay = $urandom_range(1, 30);
      stub_max   = 12'($urandom);
      capture_run(1'b1, 0, 0);
      tests++; if (cap_rst_cnt !== 1 || cap_rst_first !== 1 || cap_vfirst !== 2) begin fails++;
        $display("FAIL b2b%0d_start: got rst=%0d@%0d first_valid=%0d want 1@1 2", r, cap_rst_cnt, cap_rst_first, cap_vfirst); end
      tests++; if (stream_errs() !== 0 || cap_done_c !== exp_done_c() || cap_score !== stub_max) begin fails++;
        $display("FAIL b2b%0d_run: got bad=%0d done@%0d score=%h want 0 done@%0d score=%h",
                 r, stream_errs(), cap_done_c, cap_score, exp_done_c(), stub_max); end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL b2b_stop: got busy=%b after start dropped want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_stream_pattern();
    test_random_runs();
    test_timeout();
    test_write_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
